// File: rtl/mux4to1.sv
// Four-way WIDTH-bit selector: combinational Result plus a registered copy,
// registered selector and one-cycle selector-change strobe.
// Optional MUX4TO1_PARITY_EN adds a registered parity output Parity_q.
module mux4to1 #(
  parameter int                 WIDTH     = 32,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       Selector,
  input  logic [WIDTH-1:0] R0,
  input  logic [WIDTH-1:0] R1,
  input  logic [WIDTH-1:0] R2,
  input  logic [WIDTH-1:0] R3,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Result_q,
  output logic [1:0]       Sel_q,
  output logic             Sel_chg
`ifdef MUX4TO1_PARITY_EN
  ,output logic            Parity_q
`endif
);

  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       sel_q, sel_d;
  logic             chg_q, chg_d;

  // An unknown selector propagates as all-X rather than falling back to an input.
  always_comb begin
    Result = 'x;
    case (Selector)
      2'b00:   Result = R0;
      2'b01:   Result = R1;
      2'b10:   Result = R2;
      2'b11:   Result = R3;
      default: Result = 'x;
    endcase
  end

  always_comb begin
    result_d = Result;
    sel_d    = Selector;
    chg_d    = (Selector != sel_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= RESET_VAL;
      sel_q    <= 2'b00;
      chg_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      sel_q    <= sel_d;
      chg_q    <= chg_d;
    end
  end

  assign Result_q = result_q;
  assign Sel_q    = sel_q;
  assign Sel_chg  = chg_q;

`ifdef MUX4TO1_PARITY_EN
  logic par_q, par_d;

  assign par_d = ^Result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end

  assign Parity_q = par_q;
`endif

endmodule

// File: tb/tb_mux4to1.sv
// Scoreboard bench for mux4to1: driver pushes expected registered state,
// a monitor pops and compares after each rising edge.
module tb_mux4to1;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         clk_en = 1'b0;
  logic         rst_n = 1'b1;
  logic [1:0]   Selector = 2'b00;
  logic [W-1:0] R0 = '0, R1 = '0, R2 = '0, R3 = '0;
  logic [W-1:0] Result, Result_q;
  logic [1:0]   Sel_q;
  logic         Sel_chg;
`ifdef MUX4TO1_PARITY_EN
  logic         Parity_q;
`endif

  mux4to1 #(.WIDTH(W), .RESET_VAL('0)) dut (
    .clk(clk), .rst_n(rst_n), .Selector(Selector),
    .R0(R0), .R1(R1), .R2(R2), .R3(R3),
    .Result(Result), .Result_q(Result_q), .Sel_q(Sel_q), .Sel_chg(Sel_chg)
`ifdef MUX4TO1_PARITY_EN
    , .Parity_q(Parity_q)
`endif
  );

  always #5 clk = clk_en ? ~clk : clk;

  typedef struct {
    logic [W-1:0] res;
    logic [1:0]   sel;
    logic         chg;
    logic         par;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] rm[4];
  logic [1:0]   model_sel = 2'b00;
  logic [1:0]   cur_sel   = 2'b00;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_data(input logic [W-1:0] a, b, c, d);
    R0 = a; R1 = b; R2 = c; R3 = d;
    rm[0] = a; rm[1] = b; rm[2] = c; rm[3] = d;
  endtask

  // Drive one cycle of stimulus at the falling edge and record what the
  // next rising edge must produce.
  task automatic drive(input logic [1:0] s, input logic [W-1:0] a, b, c, d);
    exp_t e;
    @(negedge clk);
    Selector = s; cur_sel = s;
    set_data(a, b, c, d);
    #1 chk("comb_result", Result, rm[s]);
    e.res = rm[s];
    e.sel = s;
    e.chg = (s != model_sel);
    e.par = ^rm[s];
    model_sel = s;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("Result_q", Result_q, e.res);
        chk("Sel_q", {30'd0, Sel_q}, {30'd0, e.sel});
        chk("Sel_chg", {31'd0, Sel_chg}, {31'd0, e.chg});
`ifdef MUX4TO1_PARITY_EN
        chk("Parity_q", {31'd0, Parity_q}, {31'd0, e.par});
`endif
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(posedge clk);
      #3;
    end
    if (sb.size() > 0) chk("drain_timeout", W'(sb.size()), '0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_Result_q"}, Result_q, '0);
    chk({tag, "_Sel_q"}, {30'd0, Sel_q}, '0);
    chk({tag, "_Sel_chg"}, {31'd0, Sel_chg}, '0);
`ifdef MUX4TO1_PARITY_EN
    chk({tag, "_Parity_q"}, {31'd0, Parity_q}, '0);
`endif
  endtask

  initial begin : stim
    logic [1:0] seq[4];
    #1 rst_n = 1'b0;
    set_data(32'hDEADBEEF, 32'hCAFEBABE, 32'h0BADF00D, 32'h01234567);
    #1 chk_reset_state("rst_clk_stopped");

    // Clock stopped: the select path is purely combinational.
    for (int i = 0; i < 4; i++) begin
      Selector = 2'(i);
      #100 chk("stopped_sel", Result, rm[i]);
    end
    Selector = 2'b00;
    #100 chk("sel_11_to_00", Result, 32'hDEADBEEF);

    // Clock running with reset held.
    clk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      Selector = 2'(i + 1);
      #1 chk_reset_state("rst_clk_running");
      chk("rst_comb", Result, rm[i + 1]);
    end

    @(negedge clk);
    Selector = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    model_sel = 2'b00;
    drive(2'b00, rm[0], rm[1], rm[2], rm[3]);
    drive(2'b10, rm[0], rm[1], rm[2], rm[3]);
    drive(2'b10, rm[0], rm[1], rm[2], rm[3]);
    drive(2'b01, rm[0], rm[1], rm[2], rm[3]);
    drive(2'b01, rm[0], rm[1], rm[2], rm[3]);

    // Random traffic, including simultaneous data and selector changes.
    for (int i = 0; i < 200; i++)
      drive(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom);

    // Back-to-back walk with a change every cycle.
    seq[0] = 2'b11; seq[1] = 2'b00; seq[2] = 2'b01; seq[3] = 2'b10;
    for (int i = 0; i < 8; i++)
      drive(seq[i % 4], $urandom, $urandom, $urandom, $urandom);

    // Reset between edges clears the registered stage without a clock edge.
    drain();
    rst_n = 1'b0;
    #1 chk_reset_state("async_rst");
    chk("async_rst_comb", Result, rm[cur_sel]);
    model_sel = 2'b00;
    @(negedge clk);
    Selector = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++)
      drive(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
endmodule
